// File: rtl/uart_rx_framer_if.sv
// Output handshake bundle of the UART receive framer: delivered byte,
// valid/ready pair and error reporting.
interface uart_rx_framer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic                 clr_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rd_data, rd_valid, frame_err, overrun,
    input  rd_ready, clr_err
  );

  modport slave (
    input  rd_data, rd_valid, frame_err, overrun,
    output rd_ready, clr_err
  );
endinterface

// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronises rx, times mid-bit samples from an
// oversampling tick, checks the stop bit and holds each byte for a consumer.
module uart_rx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           rx,
  output logic           busy,
  uart_rx_framer_if.master rd
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [IDX_W-1:0]     bitidx, bitidx_nx;
  logic [DATA_BITS-1:0] shifter, shifter_nx;
  logic                 deliver;
  logic                 ferr_nx;
  logic                 rx_p0, rx_p1;
  logic                 rx_s;

  // Stage p0/p1: two-flop synchroniser, idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;
  assign busy = (state != S_IDLE);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bitidx_nx  = bitidx;
    shifter_nx = shifter;
    deliver    = 1'b0;
    ferr_nx    = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_nx = S_START;
            cnt_nx   = '0;
          end
        end
        S_START: begin
          // A start bit that is high again at its centre is a glitch
          if (cnt == CNT_HALF) begin
            cnt_nx = '0;
            if (!rx_s) begin
              state_nx  = S_DATA;
              bitidx_nx = '0;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt_nx     = '0;
            shifter_nx = {rx_s, shifter[DATA_BITS-1:1]};
            if (bitidx == IDX_LAST) begin
              state_nx = S_STOP;
            end else begin
              bitidx_nx = bitidx + IDX_W'(1);
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt_nx = '0;
            if (rx_s) begin
              deliver  = 1'b1;
              state_nx = S_IDLE;
            end else begin
              ferr_nx  = 1'b1;
              state_nx = S_BREAK;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          // A held-low line must return high before another start is seen
          if (rx_s) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bitidx  <= '0;
      shifter <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bitidx  <= bitidx_nx;
      shifter <= shifter_nx;
    end
  end

  // Output register: a pending byte may be popped and replaced on one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd.rd_data   <= '0;
      rd.rd_valid  <= 1'b0;
      rd.frame_err <= 1'b0;
      rd.overrun   <= 1'b0;
    end else begin
      rd.frame_err <= ferr_nx;
      if (rd.clr_err) begin
        rd.overrun <= 1'b0;
      end
      if (deliver) begin
        if (!rd.rd_valid || rd.rd_ready) begin
          rd.rd_data  <= shifter;
          rd.rd_valid <= 1'b1;
        end else begin
          rd.overrun <= 1'b1;
        end
      end else if (rd.rd_valid && rd.rd_ready) begin
        rd.rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Randomised and directed bench for uart_rx_framer against a frame-level
// reference: good frames queue their byte, bad stop bits count one error.
module tb_uart_rx_framer;

  logic clk;
  logic reset;
  logic tick;
  logic rx;
  logic busy;
  bit   tick_rand;
  bit   mon_en;

  int n_cmp;
  int n_err;
  int ferr_seen;
  int ferr_exp;
  logic [7:0] exp_q[$];

  uart_rx_framer_if #(.DATA_BITS(8)) bus ();

  uart_rx_framer #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .CNT_W     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .rx   (rx),
    .busy (busy),
    .rd   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tick = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tick = tick_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted byte must be the oldest expected good frame
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_q.size() == 0)
          chk("rd_data_spurious", {24'b0, bus.rd_data}, 32'h100);
        else
          chk("rd_data", {24'b0, bus.rd_data}, {24'b0, exp_q.pop_front()});
      end
      if (bus.frame_err) ferr_seen++;
    end
  end

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      wait_ticks(16);
    end
    if (!stop_ok) wait_ticks(hold);
    rx = 1'b1;
    wait_ticks(6);
  endtask

  task automatic send_glitch(input int lo);
    rx = 1'b0;
    wait_ticks(lo);
    rx = 1'b1;
    wait_ticks(10);
  endtask

  // With a tick every clk the stop bit is sampled on the 155th edge after rx
  // falls; pulse rd_ready or clr_err so it is seen on exactly that edge.
  task automatic send_pulse(input logic [7:0] b, input bit on_ready);
    fork
      send_frame(b, 1'b1, 0);
      begin
        repeat (154) @(posedge clk);
        #1;
        if (on_ready) bus.rd_ready = 1'b1;
        else          bus.clr_err  = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_ready = 1'b0;
        bus.clr_err  = 1'b0;
      end
    join
  endtask

  task automatic good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1, 0);
  endtask

  task automatic bad(input logic [7:0] b, input int hold);
    ferr_exp++;
    send_frame(b, 1'b0, hold);
  endtask

  task automatic check_phase(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_frame_err_count"}, 32'(ferr_seen), 32'(ferr_exp));
    chk({tag, "_overrun"}, {31'b0, bus.overrun}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ferr_seen = 0;
    ferr_exp = 0;
    tick_rand = 1'b0;
    mon_en = 1'b0;
    reset = 1'b1;
    rx = 1'b1;
    bus.rd_ready = 1'b0;
    bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", {24'b0, bus.rd_data}, 32'd0);
    chk("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("rst_frame_err", {31'b0, bus.frame_err}, 32'd0);
    chk("rst_overrun", {31'b0, bus.overrun}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    wait_ticks(4);

    // Directed frames, glitch and broken stop bit with an always-ready sink
    mon_en = 1'b1;
    bus.rd_ready = 1'b1;
    good(8'h55);
    send_glitch(5);
    chk("glitch_busy", {31'b0, busy}, 32'd0);
    chk("glitch_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    good(8'hA3);
    bad(8'h3C, 40);
    chk("break_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    good(8'h81);
    check_phase("directed");

    // Random bytes, random tick density, glitches and framing errors
    tick_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) send_glitch($urandom_range(2, 6));
      if ($urandom_range(0, 5) == 0) bad(b, $urandom_range(0, 40));
      else                           good(b);
      wait_ticks($urandom_range(0, 8));
    end
    check_phase("random");
    tick_rand = 1'b0;
    wait_ticks(2);

    // Overrun with a stalled sink, then clear
    mon_en = 1'b0;
    bus.rd_ready = 1'b0;
    send_frame(8'h12, 1'b1, 0);
    send_frame(8'h34, 1'b1, 0);
    chk("ovr_rd_data", {24'b0, bus.rd_data}, 32'h12);
    chk("ovr_rd_valid", {31'b0, bus.rd_valid}, 32'd1);
    chk("ovr_overrun", {31'b0, bus.overrun}, 32'd1);
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    chk("clr_overrun", {31'b0, bus.overrun}, 32'd0);
    chk("clr_rd_data", {24'b0, bus.rd_data}, 32'h12);

    // Pop and load on the same edge
    send_pulse(8'h34, 1'b1);
    chk("popload_rd_data", {24'b0, bus.rd_data}, 32'h34);
    chk("popload_rd_valid", {31'b0, bus.rd_valid}, 32'd1);
    chk("popload_overrun", {31'b0, bus.overrun}, 32'd0);
    bus.rd_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_ready = 1'b0;
    chk("consume_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("consume_rd_data", {24'b0, bus.rd_data}, 32'h34);

    // Overrun set and clear on the same edge: set wins
    send_frame(8'h55, 1'b1, 0);
    send_pulse(8'h66, 1'b0);
    chk("setwin_overrun", {31'b0, bus.overrun}, 32'd1);
    chk("setwin_rd_data", {24'b0, bus.rd_data}, 32'h55);

    // Reset during data bit 4 of 0xFF
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16 * 4 + 8);
    chk("midframe_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_rd_data", {24'b0, bus.rd_data}, 32'd0);
    chk("midrst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("midrst_overrun", {31'b0, bus.overrun}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_hold_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    reset = 1'b0;
    wait_ticks(4);
    mon_en = 1'b1;
    bus.rd_ready = 1'b1;
    good(8'h0F);
    check_phase("postreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
